// File: rtl/rv32i_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_types
// Description : Shared types and constants for the rv32i bus arbiter:
//               bus FSM state encoding, load/store size codes (fun3) and the
//               instruction returned on a failed fetch.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_types;

    // Bus sequencer states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        MISAL = 2'd3
    } bus_state_t;

    // Load/store size codes as carried in the instruction's fun3 field
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // addi x0, x0, 0 - handed to the core when a fetch fails
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/rv32i_bus_arbiter_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : bus_lane_align
// Description : Combinational byte-lane steering for data accesses. Derives
//               Wishbone byte selects and lane-shifted store data from the
//               low address bits and the access size, and flags accesses
//               that are not naturally aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_lane_align
    import riscv_types::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic        misal
);

    // Select lanes by access size; unknown size codes behave as words
    always_comb begin
        sel   = 4'b1111;
        misal = 1'b0;
        case (op)
            MEM_B, MEM_BU: begin
                sel   = 4'b0001 << addr_lo;
                misal = 1'b0;
            end
            MEM_H, MEM_HU: begin
                sel   = 4'b0011 << addr_lo;
                misal = addr_lo[0];
            end
            default: begin
                sel   = 4'b1111;
                misal = |addr_lo;
            end
        endcase
    end

    // Right-aligned store data moved up to its byte lane
    assign wdat = wdata << {addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/rv32i_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_bus_arbiter
// Description : Shares one Wishbone classic master between the core's
//               instruction fetch and MEM-stage data ports, one bus cycle at
//               a time, data first. Generates the core pipeline stall.
//               Optional build macro BUS_TIMEOUT_EN adds a wait-cycle
//               watchdog that aborts a bus cycle after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_bus_arbiter
    import riscv_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_op,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        stall_pipl,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    bus_state_t  r_state;
    bus_state_t  w_next_state;
    logic        r_cyc;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic [3:0]  w_sel;
    logic [31:0] w_wdat;
    logic        w_misal;
    logic        w_timeout;
    logic        w_in_bus;
    logic        w_bus_done;
    logic        w_enter_data;
    logic        w_enter_fetch;
    logic        w_unused;

    bus_lane_align u_lane_align (
        .addr_lo (d_addr[1:0]),
        .op      (d_op),
        .wdata   (d_wdata),
        .sel     (w_sel),
        .wdat    (w_wdat),
        .misal   (w_misal)
    );

    assign w_in_bus      = (r_state == FETCH) || (r_state == DATA);
    assign w_bus_done    = w_in_bus && (wb_ack_i || wb_err_i || w_timeout);
    assign w_enter_data  = (r_state == IDLE) && d_req && !w_misal;
    assign w_enter_fetch = (r_state == IDLE) && !d_req && if_req;

`ifdef BUS_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [c_CNT_W-1:0] r_wait_cnt;

    // Count cycles spent in a bus cycle; cleared while idle so each cycle starts at 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (!w_in_bus) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Abort in the TIMEOUT-th waiting cycle, so cyc is high for exactly TIMEOUT cycles
    assign w_timeout = w_in_bus && (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Fetch address bits below the word and the timeout depth are otherwise unused here
    assign w_unused = (^if_addr[1:0]) ^ (TIMEOUT != 0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: data wins ties, misaligned data never reaches the bus
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (d_req) begin
                    w_next_state = w_misal ? MISAL : DATA;
                end else if (if_req) begin
                    w_next_state = FETCH;
                end
            end
            FETCH, DATA: begin
                if (w_bus_done) begin
                    w_next_state = IDLE;
                end
            end
            MISAL:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bus-side registers: captured on entry, held stable until the cycle ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else if (w_enter_data) begin
            r_cyc <= 1'b1;
            r_we  <= d_we;
            r_adr <= {d_addr[31:2], 2'b00};
            r_dat <= w_wdat;
            r_sel <= w_sel;
        end else if (w_enter_fetch) begin
            r_cyc <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= {if_addr[31:2], 2'b00};
            r_dat <= '0;
            r_sel <= 4'b1111;
        end else if (w_bus_done) begin
            r_cyc <= 1'b0;
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;

    // Core-side outputs: acks are combinational from the slave response
    always_comb begin
        if_ack     = (r_state == FETCH) && w_bus_done;
        if_rdata   = ((r_state == FETCH) && (wb_err_i || (w_timeout && !wb_ack_i)))
                     ? NOP_INSN : wb_dat_i;
        d_ack      = ((r_state == DATA) && w_bus_done) || (r_state == MISAL);
        d_err      = ((r_state == DATA) && (wb_err_i || (w_timeout && !wb_ack_i)))
                     || (r_state == MISAL);
        d_rdata    = wb_dat_i;
        stall_pipl = (if_req && !if_ack) || (d_req && !d_ack);
    end

endmodule
`default_nettype wire

// File: doc/rv32i_bus_arbiter.md
# rv32i_bus_arbiter

Shares one Wishbone classic master port between the core's instruction-fetch port and its MEM-stage data port. It sits between the `rv32i` core and the SoC interconnect, sequences one bus cycle at a time, and generates the core's `stall_pipl` input. Data accesses take priority over fetches.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a bus cycle may wait for `wb_ack_i` before abort; only used when the timeout feature is compiled in.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch request; held high with a stable `if_addr` until `if_ack`.
- `if_addr` in 32: fetch address, word aligned (core `current_pc`).
- `if_rdata` out 32: fetched instruction; valid while `if_ack`=1.
- `if_ack` out 1: fetch complete, one-cycle pulse.
- `d_req` in 1: data request (`mem_read_mem | mem_write_mem`); held high with stable operands until `d_ack`.
- `d_we` in 1: 1 = store.
- `d_addr` in 32: byte address (`mem_addr_mem`).
- `d_wdata` in 32: store data, right-aligned.
- `d_op` in 3: fun3 size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `d_rdata` out 32: raw bus word, unaligned; the core extracts the lanes. Valid while `d_ack`=1.
- `d_ack` out 1: data access complete, one-cycle pulse.
- `d_err` out 1: data access failed, one-cycle pulse coincident with `d_ack`.
- `stall_pipl` out 1: pipeline stall to the core.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone cycle, strobe and write enable.
- `wb_adr_o` out 32: Wishbone address, word aligned (addr[1:0]=0).
- `wb_dat_o` out 32: Wishbone write data, lane shifted.
- `wb_sel_o` out 4: Wishbone byte selects.
- `wb_dat_i` in 32: Wishbone read data.
- `wb_ack_i` in 1: Wishbone acknowledge.
- `wb_err_i` in 1: Wishbone error.

## Operation
- FSM states and transitions:
  - IDLE: if `d_req`, go to DATA (or MISAL, below); else if `if_req`, go to FETCH. Data wins any tie. Fetch cannot starve, because the core stalls while a data access is pending.
  - FETCH: wait for `wb_ack_i` or `wb_err_i`, then go to IDLE.
  - DATA: wait for `wb_ack_i` or `wb_err_i`, then go to IDLE.
  - MISAL: no bus cycle is issued. Pulse `d_ack` and `d_err` for one cycle, then go to IDLE.
- Misaligned access: h/hu with addr[0]=1, or w with addr[1:0]≠0. It goes to MISAL.
- Bus signal registration:
  - `wb_cyc_o`/`wb_stb_o` are registered and high in FETCH and DATA only.
  - `wb_adr_o`, `wb_we_o`, `wb_sel_o` and `wb_dat_o` are registered on entry to FETCH or DATA and stay stable until exit.
- Byte selects:
  - b: `4'b0001 << addr[1:0]`
  - h: `4'b0011 << addr[1:0]`
  - w: `4'b1111`
  - fetch: `4'b1111`, `wb_we_o`=0.
- Store data is `d_wdata << (8*addr[1:0])`.
- Acknowledge outputs are combinational:
  - `if_ack = (FETCH & (wb_ack_i|wb_err_i))`.
  - `d_ack = (DATA & (wb_ack_i|wb_err_i)) | MISAL`.
  - `if_rdata`/`d_rdata` = `wb_dat_i`.
- Fetch error: an error on a fetch returns `if_rdata` = 32'h0000_0013 (NOP) and is otherwise ignored.
- Stall: `stall_pipl = (if_req & ~if_ack) | (d_req & ~d_ack)`.
- Request withdrawn mid-cycle: the bus cycle still completes and the resulting ack pulse is ignored by the core.

## Timing
- Reset values: all `wb_*` outputs 0, `if_ack`/`d_ack`/`d_err` 0, `stall_pipl` follows its equation, FSM = IDLE. Reset asserted mid-cycle drops `wb_cyc_o`/`wb_stb_o` immediately (asynchronous).
- Latency: a request high at edge N puts `wb_stb_o` high after edge N, so the bus cycle occupies cycle N+1. A slave acking in cycle N+1 gives the ack pulse in cycle N+1. The FSM is in IDLE at N+2, so back-to-back requests cost 2 cycles each.
- Misaligned access: ack in the cycle after the request is accepted.
- `wb_ack_i` or `wb_err_i` seen outside FETCH/DATA is ignored.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to FETCH/DATA and increments each waiting cycle.
  - When it reaches `TIMEOUT`, the FSM drops cyc/stb and returns to IDLE.
  - For a data cycle it pulses `d_ack` and `d_err`. For a fetch it pulses `if_ack` with NOP data.
- Undefined: no counter; the FSM waits for the slave indefinitely.

## Structure
- `riscv_types` holds:
  - `bus_state_t` enum {IDLE, FETCH, DATA, MISAL}.
  - `mem_op` fun3 localparams (`MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`).
  - `NOP_INSN` = 32'h0000_0013.
- Sub-module `bus_lane_align` is combinational. It takes addr[1:0], `d_op` and `d_wdata`, and produces `wb_sel_o`, `wb_dat_o` and the misalign flag.

## Test plan
- Fetch, zero-wait slave: `if_req`, `if_addr`=0x100, slave acks in the first stb cycle with 0x00500093 -> `if_ack` in that cycle with `if_rdata`=0x00500093; `stall_pipl` drops in the same cycle.
- Simultaneous `if_req` and `d_req` (sw, addr 0x2004, data 0xDEADBEEF) -> data cycle first with `wb_sel_o`=1111 and `wb_we_o`=1, then the fetch cycle.
- sb to 0x2003 with `d_wdata`=0x000000AB -> `wb_sel_o`=1000, `wb_dat_o`=0xAB000000, `wb_adr_o`=0x2000.
- lw at 0x2002 -> no `wb_cyc_o`; `d_ack`=`d_err`=1 for one cycle.
- With `BUS_TIMEOUT_EN` and `TIMEOUT`=4, slave never acks a load -> cyc drops after 4 wait cycles; `d_ack`=`d_err`=1 for one cycle.
- `reset` pulsed in the middle of a 3-wait-state cycle -> `wb_cyc_o` falls immediately; FSM = IDLE; a later ack is ignored.
